// File: rtl/logic_unit_arbiter.sv
// Two requesters share one AND/OR/XOR/NOT unit through a round-robin arbiter and a single response channel.
// Define LOGIC_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 wins ties).
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_p,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // the sender holds valid and payload stable until that cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_f;
  logic             op_id;
  logic             grant0;
  logic             grant1;
  logic             accept;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`else
  // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
  logic last_grant;
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);
`endif

  assign req0_ready = (state == IDLE) & ~rst & grant0;
  assign req1_ready = (state == IDLE) & ~rst & grant1;
  assign accept     = req0_ready | req1_ready;
  assign dbg_state  = state;

  logic [WIDTH-1:0] lu_out;
  logic             lu_err;
  logic             lu_z;
  logic             lu_n;
  logic             lu_p;

  always_comb begin
    lu_out = '0;
    lu_err = 1'b0;
    case (op_f)
      3'b000:  lu_out = op_a & op_b;
      3'b001:  lu_out = op_a | op_b;
      3'b010:  lu_out = op_a ^ op_b;
      3'b011:  lu_out = ~op_a;
      default: lu_err = 1'b1;
    endcase
    lu_z = ~lu_err & ~(|lu_out);
    lu_n = ~lu_err & lu_out[WIDTH-1];
    lu_p = ~lu_err & ~(^lu_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_f      <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_z     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_p     <= 1'b0;
      rsp_err   <= 1'b0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= grant1 ? req1_a : req0_a;
            op_b  <= grant1 ? req1_b : req0_b;
            op_f  <= grant1 ? req1_f : req0_f;
            op_id <= grant1;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
            last_grant <= grant1;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= lu_out;
          rsp_z     <= lu_z;
          rsp_n     <= lu_n;
          rsp_p     <= lu_p;
          rsp_err   <= lu_err;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: drivers push expected responses on acceptance,
// a monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_n, rsp_p, rsp_err;
  logic [15:0] rsp_out;
  logic [1:0]  dbg_state;

  // Expected response packing: {id, out[15:0], z, n, p, err}
  logic [20:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_accept_cyc = 0;
  logic        prev_valid = 1'b0;

  logic_unit_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_p(rsp_p), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one request and hold it until accepted; optionally push its expected response.
  task automatic drive(input bit which, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] f, input bit push, input logic [20:0] exp);
    bit got = 0;
    @(negedge clk);
    if (which) begin req1_valid = 1; req1_a = a; req1_b = b; req1_f = f; end
    else       begin req0_valid = 1; req0_a = a; req0_b = b; req0_f = f; end
    for (int n = 0; n < 200; n++) begin
      #1;
      if ((which ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout req%0d: got no ready, required ready", which);
    end else begin
      if (push) exp_q.push_back(exp);
      last_accept_cyc = cyc;
      @(posedge clk);
    end
    #1;
    if (which) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #3;
      if (exp_q.size() == 0 && !rsp_valid) return;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    #2;
    if (rsp_valid && !prev_valid)
      check("latency", cyc - last_accept_cyc, 2);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {11'd0, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err}, 32'hdead);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("rsp", {11'd0, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err}, {11'd0, e});
      end
    end
    prev_valid = rsp_valid;
  end

  logic [21:0] snap;

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_f = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_f = 0;

    // Reset: outputs zero, readies held low even with valid requests
    @(negedge clk); req0_valid = 1; req1_valid = 1;
    @(negedge clk); #1;
    check("reset_outputs", {rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err, dbg_state}, 0);
    check("ready_in_reset", {req0_ready, req1_ready}, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst = 0;

    // AND from requester 0
    drive(0, 16'hF0F0, 16'hFF00, 3'b000, 1, {1'b0, 16'hF000, 1'b0, 1'b1, 1'b1, 1'b0});
    drain();

    // Tie after reset: requester 0 first, then requester 1
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    fork
      drive(0, 16'h0000, 16'h0000, 3'b001, 1, {1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
      drive(1, 16'hAAAA, 16'h5555, 3'b010, 1, {1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
    join
    drain();

    // NOT and an illegal code from requester 1
    drive(1, 16'h0001, 16'h1234, 3'b011, 1, {1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0});
    drive(1, 16'hFFFF, 16'hFFFF, 3'b101, 1, {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
    drain();

    // Backpressure with both requests pending
    rsp_ready = 0;
    fork
      drive(0, 16'hFFFF, 16'h0F0F, 3'b000, 1, {1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b0});
      drive(1, 16'h8000, 16'h0001, 3'b001, 1, {1'b1, 16'h8001, 1'b0, 1'b1, 1'b1, 1'b0});
      begin
        for (int n = 0; n < 50; n++) begin
          @(negedge clk); #1;
          if (rsp_valid) break;
        end
        check("bp_valid_rise", rsp_valid, 1);
        snap = {rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err};
        for (int i = 0; i < 5; i++) begin
          @(negedge clk); #1;
          check("bp_stable", {rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err, req0_ready, req1_ready},
                {snap, 2'b00});
        end
        @(negedge clk); rsp_ready = 1;
        @(negedge clk); #1;
        check("bp_next_grant", {req0_ready, req1_ready}, 2'b01);
      end
    join
    drain();

    // Reset while in EXEC discards the operation
    drive(0, 16'h1234, 16'h00FF, 3'b010, 0, '0);
    check("in_exec", dbg_state, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; #1;
    check("exec_reset_outputs",
          {rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_p, rsp_err, dbg_state, req0_ready, req1_ready}, 0);
    repeat (6) @(negedge clk);
    #3;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
